// File: rtl/alu_exu.sv
// alu_exu: registered integer execute unit (RV32I/RV64I ALU ops, jumps, branches,
// optional M extension with an iterative radix-2 divider).
// Optional feature macro: ALU_EXU_M_EN (enables MUL*/DIV*/REM* ops 20-27; when
// undefined those op codes retire as illegal and no multiplier/divider exists).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_flush             drop held result and abort a running divide
//   i_valid / o_ready   request handshake
//   i_op, i_a, i_b      op code and register operands
//   i_imm_en, i_imm     immediate select / immediate value
//   i_pc                PC of the op
//   o_valid / i_ready   result handshake
//   o_wr_en, o_data     rd write enable and value
//   o_jump_valid/_pc    redirect request and target
//   o_illegal           unsupported op code
module alu_exu #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [4:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_imm_en,
    input  logic [DW-1:0] i_imm,
    input  logic [AW-1:0] i_pc,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_wr_en,
    output logic [DW-1:0] o_data,
    output logic          o_jump_valid,
    output logic [AW-1:0] o_jump_pc,
    output logic          o_illegal
);

    localparam int unsigned SHW = $clog2(DW);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLT  = 5'd2,  OP_SLTU = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4,  OP_OR   = 5'd5,  OP_AND  = 5'd6,  OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8,  OP_SRA  = 5'd9,  OP_LUI  = 5'd10, OP_AUIPC = 5'd11;
    localparam logic [4:0] OP_JAL  = 5'd12, OP_JALR = 5'd13, OP_BEQ  = 5'd14, OP_BNE  = 5'd15;
    localparam logic [4:0] OP_BLT  = 5'd16, OP_BGE  = 5'd17, OP_BLTU = 5'd18, OP_BGEU = 5'd19;
`ifdef ALU_EXU_M_EN
    localparam logic [4:0] OP_MUL  = 5'd20, OP_MULH = 5'd21, OP_MULHSU = 5'd22, OP_MULHU = 5'd23;
    localparam logic [4:0] OP_DIV  = 5'd24, OP_DIVU = 5'd25, OP_REM  = 5'd26, OP_REMU = 5'd27;
    localparam int unsigned CW = $clog2(DW);
`endif

    // Result registers
    logic          valid_q, valid_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] data_q, data_d;
    logic          jv_q, jv_d;
    logic [AW-1:0] jpc_q, jpc_d;
    logic          ill_q, ill_d;

    logic          accept;

    // Single-cycle result
    logic [DW-1:0] opb;
    logic [SHW-1:0] shamt;
    logic [DW-1:0] pc_ext;
    logic [AW-1:0] br_tgt;
    logic [DW-1:0] jalr_sum;
    logic [DW-1:0] res_data;
    logic          res_wr, res_jv, res_ill;
    logic [AW-1:0] res_jpc;

    assign opb      = i_imm_en ? i_imm : i_b;
    assign shamt    = opb[SHW-1:0];
    assign pc_ext   = DW'(i_pc);
    assign br_tgt   = i_pc + AW'(i_imm);
    assign jalr_sum = i_a + i_imm;

`ifdef ALU_EXU_M_EN
    typedef enum logic {S_IDLE, S_DIV} state_e;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic          negq_q, negq_d, negr_q, negr_d, isrem_q, isrem_d;

    logic          start_div;
    logic [2*DW-1:0] mul_a, mul_b, mul_p;
    logic          a_sgn, b_sgn;
    logic          div_signed, a_neg, b_neg, div_ovf;
    logic [DW-1:0] a_mag, b_mag;
    logic [DW:0]   rem_sh, diff;
    logic          ge;
    logic [DW-1:0] rem_nx, quo_nx, div_res;

    // One shared 2DW multiplier; operand extension selects signedness
    assign a_sgn = (i_op == OP_MULH) | (i_op == OP_MULHSU);
    assign b_sgn = (i_op == OP_MULH);
    assign mul_a = {{DW{a_sgn & i_a[DW-1]}}, i_a};
    assign mul_b = {{DW{b_sgn & i_b[DW-1]}}, i_b};
    assign mul_p = mul_a * mul_b;

    // Divider operand conditioning: divide magnitudes, fix signs at the end
    assign div_signed = (i_op == OP_DIV) | (i_op == OP_REM);
    assign a_neg      = div_signed & i_a[DW-1];
    assign b_neg      = div_signed & i_b[DW-1];
    assign a_mag      = a_neg ? -i_a : i_a;
    assign b_mag      = b_neg ? -i_b : i_b;
    assign div_ovf    = div_signed & (i_a == {1'b1, {(DW-1){1'b0}}}) & (&i_b);

    // One restoring-division step
    assign rem_sh  = {rem_q, quo_q[DW-1]};
    assign diff    = rem_sh - {1'b0, dvs_q};
    assign ge      = ~diff[DW];
    assign rem_nx  = ge ? diff[DW-1:0] : rem_sh[DW-1:0];
    assign quo_nx  = {quo_q[DW-2:0], ge};
    assign div_res = isrem_q ? (negr_q ? -rem_nx : rem_nx) : (negq_q ? -quo_nx : quo_nx);

    assign o_ready = (state_q == S_IDLE) & (~valid_q | i_ready) & ~i_flush;
`else
    assign o_ready = (~valid_q | i_ready) & ~i_flush;
`endif

    assign accept = i_valid & o_ready;

    // Op decode and single-cycle datapath
    always_comb begin : alu_comb
        res_data = '0;
        res_wr   = 1'b1;
        res_jv   = 1'b0;
        res_jpc  = '0;
        res_ill  = 1'b0;
`ifdef ALU_EXU_M_EN
        start_div = 1'b0;
`endif
        case (i_op)
            OP_ADD:   res_data = i_a + opb;
            OP_SUB:   res_data = i_a - opb;
            OP_SLT:   res_data = DW'($signed(i_a) < $signed(opb));
            OP_SLTU:  res_data = DW'(i_a < opb);
            OP_XOR:   res_data = i_a ^ opb;
            OP_OR:    res_data = i_a | opb;
            OP_AND:   res_data = i_a & opb;
            OP_SLL:   res_data = i_a << shamt;
            OP_SRL:   res_data = i_a >> shamt;
            OP_SRA:   res_data = $unsigned($signed(i_a) >>> shamt);
            OP_LUI:   res_data = i_imm;
            OP_AUIPC: res_data = i_imm + pc_ext;
            OP_JAL: begin
                res_data = pc_ext + DW'(4);
                res_jv   = 1'b1;
                res_jpc  = br_tgt;
            end
            OP_JALR: begin
                res_data = pc_ext + DW'(4);
                res_jv   = 1'b1;
                res_jpc  = AW'(jalr_sum) & ~AW'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                res_wr  = 1'b0;
                res_jpc = br_tgt;
                case (i_op)
                    OP_BEQ:  res_jv = (i_a == i_b);
                    OP_BNE:  res_jv = (i_a != i_b);
                    OP_BLT:  res_jv = ($signed(i_a) < $signed(i_b));
                    OP_BGE:  res_jv = ($signed(i_a) >= $signed(i_b));
                    OP_BLTU: res_jv = (i_a < i_b);
                    default: res_jv = (i_a >= i_b);
                endcase
            end
`ifdef ALU_EXU_M_EN
            OP_MUL:                       res_data = mul_p[DW-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_data = mul_p[2*DW-1:DW];
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                // Divide-by-zero and signed overflow resolve without iterating
                if (i_b == '0) begin
                    res_data = ((i_op == OP_DIV) | (i_op == OP_DIVU)) ? '1 : i_a;
                end else if (div_ovf) begin
                    res_data = (i_op == OP_DIV) ? i_a : '0;
                end else begin
                    start_div = 1'b1;
                end
            end
`endif
            default: begin
                res_wr  = 1'b0;
                res_ill = 1'b1;
            end
        endcase
    end

    // Next-state: handshake, FSM and result capture
    always_comb begin : next_comb
        valid_d = valid_q;
        wr_d    = wr_q;
        data_d  = data_q;
        jv_d    = jv_q;
        jpc_d   = jpc_q;
        ill_d   = ill_q;
`ifdef ALU_EXU_M_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        isrem_d = isrem_q;
`endif
        if (valid_q & i_ready) valid_d = 1'b0;
`ifdef ALU_EXU_M_EN
        case (state_q)
            S_IDLE: begin
                if (accept && start_div) begin
                    state_d = S_DIV;
                    cnt_d   = CW'(DW - 1);
                    quo_d   = a_mag;
                    rem_d   = '0;
                    dvs_d   = b_mag;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    isrem_d = (i_op == OP_REM) | (i_op == OP_REMU);
                    valid_d = 1'b0;
                end else if (accept) begin
                    valid_d = 1'b1;
                    wr_d    = res_wr;
                    data_d  = res_data;
                    jv_d    = res_jv;
                    jpc_d   = res_jpc;
                    ill_d   = res_ill;
                end
            end
            S_DIV: begin
                quo_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    valid_d = 1'b1;
                    wr_d    = 1'b1;
                    data_d  = div_res;
                    jv_d    = 1'b0;
                    jpc_d   = '0;
                    ill_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
`else
        if (accept) begin
            valid_d = 1'b1;
            wr_d    = res_wr;
            data_d  = res_data;
            jv_d    = res_jv;
            jpc_d   = res_jpc;
            ill_d   = res_ill;
        end
`endif
        // Flush overrides accept and retire
        if (i_flush) begin
            valid_d = 1'b0;
`ifdef ALU_EXU_M_EN
            state_d = S_IDLE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            jv_q    <= 1'b0;
            jpc_q   <= '0;
            ill_q   <= 1'b0;
`ifdef ALU_EXU_M_EN
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            isrem_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            jv_q    <= jv_d;
            jpc_q   <= jpc_d;
            ill_q   <= ill_d;
`ifdef ALU_EXU_M_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            isrem_q <= isrem_d;
`endif
        end
    end

    assign o_valid      = valid_q;
    assign o_wr_en      = wr_q;
    assign o_data       = data_q;
    assign o_jump_valid = jv_q;
    assign o_jump_pc    = jpc_q;
    assign o_illegal    = ill_q;

endmodule

// File: tb/tb_alu_exu.sv
// tb_alu_exu: scoreboard bench for alu_exu (DW=AW=32). Expected results are queued
// when an op is issued and compared when the unit retires it.
module tb_alu_exu;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLT = 5'd2, OP_SLTU = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4, OP_OR = 5'd5, OP_AND = 5'd6, OP_SLL = 5'd7;
    localparam logic [4:0] OP_SRL = 5'd8, OP_SRA = 5'd9, OP_LUI = 5'd10, OP_AUIPC = 5'd11;
    localparam logic [4:0] OP_JAL = 5'd12, OP_JALR = 5'd13, OP_BEQ = 5'd14, OP_BNE = 5'd15;
    localparam logic [4:0] OP_BLT = 5'd16, OP_BGE = 5'd17, OP_BLTU = 5'd18, OP_BGEU = 5'd19;
    localparam logic [4:0] OP_MUL = 5'd20, OP_MULH = 5'd21, OP_MULHSU = 5'd22, OP_MULHU = 5'd23;
    localparam logic [4:0] OP_DIV = 5'd24, OP_DIVU = 5'd25, OP_REM = 5'd26, OP_REMU = 5'd27;

    logic          clk = 1'b0;
    logic          rst_n, i_flush, i_valid, o_ready, i_imm_en, o_valid, i_ready;
    logic [4:0]    i_op;
    logic [DW-1:0] i_a, i_b, i_imm, o_data;
    logic [AW-1:0] i_pc, o_jump_pc;
    logic          o_wr_en, o_jump_valid, o_illegal;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alu_exu #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_imm_en(i_imm_en), .i_imm(i_imm), .i_pc(i_pc),
        .o_valid(o_valid), .i_ready(i_ready), .o_wr_en(o_wr_en), .o_data(o_data),
        .o_jump_valid(o_jump_valid), .o_jump_pc(o_jump_pc), .o_illegal(o_illegal)
    );

    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic        jv;
        logic [31:0] jpc;
        logic        ill;
        bit          cd;   // compare o_data
        bit          cj;   // compare o_jump_pc
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic        ie;
        logic [31:0] imm, pc;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic exp_t mk(logic [31:0] data, logic wr, logic jv, logic [31:0] jpc,
                                logic ill, bit cd, bit cj);
        exp_t e;
        e.data = data; e.wr = wr; e.jv = jv; e.jpc = jpc; e.ill = ill; e.cd = cd; e.cj = cj;
        return e;
    endfunction

    function automatic vec_t vv(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic ie,
                                logic [31:0] imm, logic [31:0] pc, exp_t e);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.ie = ie; v.imm = imm; v.pc = pc; v.e = e;
        return v;
    endfunction

    // Compare a retiring result (if any) against the queue head, then advance to next negedge
    task automatic tick();
        exp_t e;
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got data=%h wr=%b jv=%b ill=%b", o_data, o_wr_en, o_jump_valid, o_illegal);
            end else begin
                e = sb.pop_front();
                if (o_wr_en !== e.wr || o_jump_valid !== e.jv || o_illegal !== e.ill ||
                    (e.cd && o_data !== e.data) || (e.cj && o_jump_pc !== e.jpc)) begin
                    errors++;
                    $display("FAIL sb_result got data=%h wr=%b jv=%b jpc=%h ill=%b expected data=%h wr=%b jv=%b jpc=%h ill=%b",
                             o_data, o_wr_en, o_jump_valid, o_jump_pc, o_illegal, e.data, e.wr, e.jv, e.jpc, e.ill);
                end
            end
        end
        @(negedge clk);
    endtask

    // Issue one op; returns at the negedge just after it was accepted
    task automatic send(input vec_t v, input bit push);
        int n;
        if (push) sb.push_back(v.e);
        i_valid = 1'b1; i_op = v.op; i_a = v.a; i_b = v.b;
        i_imm_en = v.ie; i_imm = v.imm; i_pc = v.pc;
        #1;
        n = 0;
        while (o_ready !== 1'b1 && n < 100) begin
            tick(); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout op=%0d", v.op);
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin tick(); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({o_valid, o_wr_en, o_jump_valid, o_illegal} !== 4'b0000 || o_data !== '0 ||
            o_jump_pc !== '0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b wr=%b jv=%b ill=%b data=%h jpc=%h rdy=%b required zeros rdy=1",
                     o_valid, o_wr_en, o_jump_valid, o_illegal, o_data, o_jump_pc, o_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        vec_t v[$];
        v.push_back(vv(OP_ADD,  32'hFFFFFFFF, 32'd1, 0, 0, 0, mk(32'h0, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_SUB,  32'd5, 32'd7, 0, 0, 0, mk(32'hFFFFFFFE, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_SLT,  32'hFFFFFFFF, 32'd1, 0, 0, 0, mk(32'd1, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_SLTU, 32'hFFFFFFFF, 32'd1, 0, 0, 0, mk(32'd0, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_XOR,  32'h0000F0F0, 32'h00000FF0, 0, 0, 0, mk(32'h0000FF00, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_OR,   32'h0000F000, 32'h0000FFFF, 1, 32'h0000000F, 0, mk(32'h0000F00F, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_AND,  32'h0000F0F0, 32'd0, 1, 32'h000000FF, 0, mk(32'h000000F0, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_SLL,  32'd1, 32'd36, 0, 0, 0, mk(32'h00000010, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_SRL,  32'h80000000, 32'd4, 0, 0, 0, mk(32'h08000000, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_SRA,  32'h80000000, 32'd4, 0, 0, 0, mk(32'hF8000000, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_SRA,  32'h80000000, 32'd0, 1, 32'd31, 0, mk(32'hFFFFFFFF, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_LUI,  0, 0, 0, 32'h12345000, 0, mk(32'h12345000, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_AUIPC, 0, 0, 0, 32'h00001000, 32'h200, mk(32'h00001200, 1, 0, 0, 0, 1, 0)));
        v.push_back(vv(OP_JAL,  0, 0, 0, 32'h40, 32'h100, mk(32'h104, 1, 1, 32'h140, 0, 1, 1)));
        v.push_back(vv(OP_JALR, 32'h1001, 0, 0, 32'h10, 32'h300, mk(32'h304, 1, 1, 32'h1010, 0, 1, 1)));
        v.push_back(vv(OP_JALR, 32'h2000, 0, 0, 32'hFFFFFFFC, 32'h300, mk(32'h304, 1, 1, 32'h1FFC, 0, 1, 1)));
        v.push_back(vv(OP_BEQ,  32'd5, 32'd5, 0, 32'hFFFFFFF0, 32'h100, mk(0, 0, 1, 32'hF0, 0, 0, 1)));
        v.push_back(vv(OP_BNE,  32'd5, 32'd5, 0, 32'h20, 32'h100, mk(0, 0, 0, 32'h120, 0, 0, 1)));
        v.push_back(vv(OP_BLT,  32'hFFFFFFFF, 32'd1, 0, 32'h20, 32'h100, mk(0, 0, 1, 32'h120, 0, 0, 1)));
        v.push_back(vv(OP_BLTU, 32'hFFFFFFFF, 32'd1, 0, 32'h20, 32'h100, mk(0, 0, 0, 32'h120, 0, 0, 1)));
        v.push_back(vv(OP_BGE,  32'hFFFFFFFF, 32'd1, 0, 32'h20, 32'h100, mk(0, 0, 0, 32'h120, 0, 0, 1)));
        v.push_back(vv(OP_BGEU, 32'hFFFFFFFF, 32'd1, 0, 32'h20, 32'h100, mk(0, 0, 1, 32'h120, 0, 0, 1)));
        v.push_back(vv(5'd28,   32'd3, 32'd4, 0, 0, 0, mk(32'h0, 0, 0, 0, 1, 1, 0)));
        v.push_back(vv(5'd31,   32'd3, 32'd4, 0, 0, 0, mk(32'h0, 0, 0, 0, 1, 1, 0)));
        foreach (v[i]) begin
            send(v[i], 1'b1);
            checks++;
            if (o_valid !== 1'b1) begin
                errors++;
                $display("FAIL alu_latency op=%0d o_valid=%b required=1", v[i].op, o_valid);
            end
        end
        drain();
    endtask

`ifdef ALU_EXU_M_EN
    task automatic test_mul_div();
        vec_t f[$];
        vec_t d[$];
        int   k;
        bit   bad;
        f.push_back(vv(OP_MUL,    32'd3, 32'd4, 0, 0, 0, mk(32'd12, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, mk(32'h0, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, mk(32'hFFFFFFFE, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_MULHSU, 32'hFFFFFFFF, 32'd2, 0, 0, 0, mk(32'hFFFFFFFF, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_MULH,   32'h80000000, 32'h80000000, 0, 0, 0, mk(32'h40000000, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_DIVU,   32'd5, 32'd0, 0, 0, 0, mk(32'hFFFFFFFF, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_DIV,    32'd5, 32'd0, 0, 0, 0, mk(32'hFFFFFFFF, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_REM,    32'd5, 32'd0, 0, 0, 0, mk(32'd5, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_REMU,   32'd5, 32'd0, 0, 0, 0, mk(32'd5, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_REM,    32'h80000000, 32'hFFFFFFFF, 0, 0, 0, mk(32'h0, 1, 0, 0, 0, 1, 0)));
        f.push_back(vv(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 0, 0, 0, mk(32'h80000000, 1, 0, 0, 0, 1, 0)));
        foreach (f[i]) begin
            send(f[i], 1'b1);
            checks++;
            if (o_valid !== 1'b1) begin
                errors++;
                $display("FAIL m_fast_latency op=%0d o_valid=%b required=1", f[i].op, o_valid);
            end
        end
        d.push_back(vv(OP_DIV,  32'hFFFFFFF9, 32'd2, 0, 0, 0, mk(32'hFFFFFFFD, 1, 0, 0, 0, 1, 0)));
        d.push_back(vv(OP_REM,  32'hFFFFFFF9, 32'd2, 0, 0, 0, mk(32'hFFFFFFFF, 1, 0, 0, 0, 1, 0)));
        d.push_back(vv(OP_DIV,  32'd7, 32'hFFFFFFFE, 0, 0, 0, mk(32'hFFFFFFFD, 1, 0, 0, 0, 1, 0)));
        d.push_back(vv(OP_REM,  32'd7, 32'hFFFFFFFE, 0, 0, 0, mk(32'd1, 1, 0, 0, 0, 1, 0)));
        d.push_back(vv(OP_DIVU, 32'd100, 32'd7, 0, 0, 0, mk(32'd14, 1, 0, 0, 0, 1, 0)));
        d.push_back(vv(OP_REMU, 32'd100, 32'd7, 0, 0, 0, mk(32'd2, 1, 0, 0, 0, 1, 0)));
        d.push_back(vv(OP_DIVU, 32'hFFFFFFFF, 32'd1, 0, 0, 0, mk(32'hFFFFFFFF, 1, 0, 0, 0, 1, 0)));
        d.push_back(vv(OP_DIV,  32'h80000000, 32'd2, 0, 0, 0, mk(32'hC0000000, 1, 0, 0, 0, 1, 0)));
        foreach (d[i]) begin
            send(d[i], 1'b1);
            k = 1; bad = 0;
            while (o_valid !== 1'b1 && k < 100) begin
                if (o_ready !== 1'b0) bad = 1;
                tick(); k++;
            end
            checks++;
            if (k != int'(DW) + 1 || bad) begin
                errors++;
                $display("FAIL div_latency op=%0d got cycles=%0d ready_seen=%0b required cycles=%0d ready_seen=0",
                         d[i].op, k, bad, DW + 1);
            end
        end
        drain();
    endtask

    task automatic test_div_abort();
        bit seen;
        // Flush in the tenth cycle of a divide
        send(vv(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)), 1'b0);
        repeat (9) tick();
        i_flush = 1'b1; #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready_low got=%b required=0", o_ready);
        end
        tick();
        i_flush = 1'b0; #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL div_flush got valid=%b ready=%b required valid=0 ready=1", o_valid, o_ready);
        end
        seen = 0;
        repeat (40) begin if (o_valid === 1'b1) seen = 1; tick(); end
        checks++;
        if (seen) begin errors++; $display("FAIL div_flush_leak got o_valid=1 required=0"); end
        // Reset in the middle of a divide
        send(vv(OP_DIVU, 32'd100, 32'd7, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)), 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({o_valid, o_wr_en, o_jump_valid, o_illegal} !== 4'b0000 || o_data !== '0 ||
            o_jump_pc !== '0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL div_reset got v=%b wr=%b data=%h rdy=%b required zeros rdy=1",
                     o_valid, o_wr_en, o_data, o_ready);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin if (o_valid === 1'b1) seen = 1; tick(); end
        checks++;
        if (seen) begin errors++; $display("FAIL div_reset_leak got o_valid=1 required=0"); end
    endtask
`else
    task automatic test_m_disabled();
        vec_t v[$];
        v.push_back(vv(OP_MUL,   32'd3, 32'd4, 0, 0, 0, mk(32'h0, 0, 0, 0, 1, 1, 0)));
        v.push_back(vv(OP_MULHU, 32'hFFFFFFFF, 32'd2, 0, 0, 0, mk(32'h0, 0, 0, 0, 1, 1, 0)));
        v.push_back(vv(OP_DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 0, mk(32'h0, 0, 0, 0, 1, 1, 0)));
        v.push_back(vv(OP_REMU,  32'd100, 32'd7, 0, 0, 0, mk(32'h0, 0, 0, 0, 1, 1, 0)));
        foreach (v[i]) begin
            send(v[i], 1'b1);
            checks++;
            if (o_valid !== 1'b1) begin
                errors++;
                $display("FAIL m_off_latency op=%0d o_valid=%b required=1", v[i].op, o_valid);
            end
        end
        drain();
    endtask
`endif

    task automatic test_hold_flush();
        // Result held while downstream stalls
        i_ready = 1'b0;
        send(vv(OP_ADD, 32'd1, 32'd2, 0, 0, 0, mk(32'd3, 1, 0, 0, 0, 1, 0)), 1'b1);
        repeat (3) begin
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== 32'd3) begin
                errors++;
                $display("FAIL hold got valid=%b ready=%b data=%h required 1 0 00000003", o_valid, o_ready, o_data);
            end
            tick();
        end
        i_ready = 1'b1;
        drain();
        // Flush drops a held result
        i_ready = 1'b0;
        send(vv(OP_SUB, 32'd9, 32'd4, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)), 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0; #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL flush_held got valid=%b ready=%b required valid=0 ready=1", o_valid, o_ready);
        end
        i_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [31:0] a, b, r;
        logic [4:0]  op;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            case (i % 4)
                0: begin op = OP_ADD; r = a + b; end
                1: begin op = OP_SUB; r = a - b; end
                2: begin op = OP_XOR; r = a ^ b; end
                default: begin op = OP_AND; r = a & b; end
            endcase
            send(vv(op, a, b, 0, 0, 0, mk(r, 1, 0, 0, 0, 1, 0)), 1'b1);
        end
        checks++;
        if (cyc - c0 != 8) begin
            errors++; $display("FAIL back_to_back_rate got cycles=%0d required=8", cyc - c0);
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_op = '0; i_a = '0; i_b = '0; i_imm_en = 1'b0; i_imm = '0; i_pc = '0;
        @(negedge clk);
        test_reset();
        test_alu();
`ifdef ALU_EXU_M_EN
        test_mul_div();
        test_div_abort();
`else
        test_m_disabled();
`endif
        test_hold_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
